// File: rtl/pkg_cpu.sv
// CPU bus encodings shared between the CPU model and its bus peripherals.
package pkg_cpu;

  // Data access size driven on the CPU data bus alongside every address.
  typedef enum logic {
    cpu_data_acc_sz_8  = 1'b0,
    cpu_data_acc_sz_16 = 1'b1
  } cpu_data_acc_sz_t;

endpackage : pkg_cpu

// File: rtl/pkg_tb_mem.sv
// Types and defaults for the bench memory port and its write-trace FIFO.
package pkg_tb_mem;

  localparam int unsigned TB_MEM_BYTES   = 256;
  localparam int unsigned TB_TRACE_DEPTH = 4;

  // One observed CPU store: masked byte address and the byte written.
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } tb_trace_entry;

  // Per-cycle classification of the CPU bus access; all zero when the
  // access is suppressed (reset or preload cycle).
  typedef struct packed {
    logic rd;        // read of any size
    logic wide;      // read is 16-bit
    logic wr8;       // accepted byte write
    logic wr16;      // rejected 16-bit write
    logic misalign;  // 16-bit read at an odd address
    logic oob;       // address beyond the memory, wraps
  } cpu_access_t;

  // Activity counters stick at all-ones instead of wrapping to zero.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage : pkg_tb_mem

// File: rtl/tb_mem_port_if.sv
// CPU data bus, preload path and write-trace stream of the bench memory port.
interface tb_mem_port_if;

  // CPU data bus
  logic [15:0] cpu_addr;
  logic        cpu_acc_sz;
  logic        cpu_we;
  logic [15:0] cpu_wdata;
  logic [15:0] rdata;

  // Preload path
  logic        load_en;
  logic [15:0] load_addr;
  logic [7:0]  load_data;

  // Write-trace stream
  logic        trace_valid;
  logic        trace_ready;
  logic [15:0] trace_addr;
  logic [7:0]  trace_data;

  // Side that issues accesses, preloads memory and consumes the trace.
  modport master (
    output cpu_addr, cpu_acc_sz, cpu_we, cpu_wdata,
    output load_en, load_addr, load_data,
    output trace_ready,
    input  rdata, trace_valid, trace_addr, trace_data
  );

  // Memory port side.
  modport slave (
    input  cpu_addr, cpu_acc_sz, cpu_we, cpu_wdata,
    input  load_en, load_addr, load_data,
    input  trace_ready,
    output rdata, trace_valid, trace_addr, trace_data
  );

endinterface : tb_mem_port_if

// File: rtl/tb_trace_fifo.sv
// Synchronous FIFO of trace entries. Pointers carry one extra wrap bit so
// full and empty fall out of a plain pointer compare. A push into a full
// FIFO is accepted only when a pop frees a slot in the same cycle.
module tb_trace_fifo
  import pkg_tb_mem::*;
#(
  parameter int unsigned DEPTH = TB_TRACE_DEPTH
) (
  input  logic          tb_clk,
  input  logic          reset,
  input  logic          push,
  input  tb_trace_entry push_entry,
  input  logic          pop,
  output tb_trace_entry head,
  output logic          valid,
  output logic          full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;
  tb_trace_entry store_q [DEPTH];
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Advance read/write pointers; reset discards all queued entries.
  always_ff @(posedge tb_clk) begin
    // NOTE: state registers take non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Capture pushed entries into the slot addressed by the write pointer.
  always_ff @(posedge tb_clk) begin
    // NOTE: storage is left out of reset on purpose; the pointers alone
    // define which slots are live, and an unreset array maps onto RAM.
    if (do_push) store_q[wr_ptr_q[AW-1:0]] <= push_entry;
  end

  // Head reads as zero while empty so a reset FIFO presents clean outputs.
  assign valid = !empty;
  assign head  = empty ? '0 : store_q[rd_ptr_q[AW-1:0]];

endmodule : tb_trace_fifo

// File: rtl/tb_mem_port.sv
// Bench memory port on the CPU data bus: byte-addressed big-endian memory
// with registered reads, byte writes, a preload path usable while the CPU
// is held in reset, a write-trace FIFO, sticky error flags and saturating
// activity counters. Every non-reset, non-preload cycle is a CPU access.
module tb_mem_port
  import pkg_cpu::*;
  import pkg_tb_mem::*;
#(
  parameter int unsigned MEM_BYTES   = TB_MEM_BYTES,
  parameter int unsigned TRACE_DEPTH = TB_TRACE_DEPTH
) (
  input  logic         tb_clk,
  input  logic         reset,
  tb_mem_port_if.slave bus,
  output logic         err_wr16,
  output logic         err_misalign,
  output logic         err_oob,
  output logic         trace_overflow,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count
);

  localparam int unsigned AW        = $clog2(MEM_BYTES);
  localparam logic [15:0] ADDR_MASK = 16'(MEM_BYTES - 1);

  logic [7:0]    mem_q [MEM_BYTES];
  logic [15:0]   rdata_q;
  logic [15:0]   cpu_masked;
  logic [AW-1:0] cpu_idx;
  logic [AW-1:0] pair_hi_idx;
  logic [AW-1:0] pair_lo_idx;
  logic [AW-1:0] load_idx;
  cpu_access_t   acc;

  tb_trace_entry push_entry;
  tb_trace_entry fifo_head;
  logic          fifo_valid;
  logic          fifo_full;
  logic          fifo_pop;

  // Only the low byte of write data and the low address bits of the
  // preload address reach the memory array.
  logic          unused_bits;
  assign unused_bits = ^{bus.cpu_wdata[15:8], bus.load_addr};

  // Addresses wrap onto the array; a 16-bit read uses the aligned pair.
  assign cpu_masked  = bus.cpu_addr & ADDR_MASK;
  assign cpu_idx     = cpu_masked[AW-1:0];
  assign pair_hi_idx = {cpu_idx[AW-1:1], 1'b0};
  assign pair_lo_idx = {cpu_idx[AW-1:1], 1'b1};
  assign load_idx    = bus.load_addr[AW-1:0];

  // Classify this cycle's CPU access; suppressed during reset and preload.
  always_comb begin
    // NOTE: the default assignment up front guarantees every field is
    // written on every path, so no latch is inferred.
    acc = '0;
    if (!reset && !bus.load_en) begin
      acc.oob = ((bus.cpu_addr & ~ADDR_MASK) != 16'h0000);
      if (!bus.cpu_we) begin
        acc.rd       = 1'b1;
        acc.wide     = (bus.cpu_acc_sz == cpu_data_acc_sz_16);
        acc.misalign = acc.wide && bus.cpu_addr[0];
      end else if (bus.cpu_acc_sz == cpu_data_acc_sz_16) begin
        acc.wr16 = 1'b1;
      end else begin
        acc.wr8 = 1'b1;
      end
    end
  end

  // Memory array: preload has priority and works during reset; CPU byte
  // writes land only on accepted 8-bit write cycles.
  always_ff @(posedge tb_clk) begin
    if (bus.load_en) begin
      mem_q[load_idx] <= bus.load_data;
    end else if (acc.wr8) begin
      mem_q[cpu_idx] <= bus.cpu_wdata[7:0];
    end
  end

  // Registered read data, big-endian for 16-bit reads; held on other cycles.
  always_ff @(posedge tb_clk) begin
    if (reset) begin
      rdata_q <= 16'h0000;
    end else if (acc.rd) begin
      if (acc.wide) rdata_q <= {mem_q[pair_hi_idx], mem_q[pair_lo_idx]};
      else          rdata_q <= {8'h00, mem_q[cpu_idx]};
    end
  end

  assign bus.rdata = rdata_q;

  // Trace every accepted byte write; the consumer pops on valid && ready.
  assign push_entry = '{addr: cpu_masked, data: bus.cpu_wdata[7:0]};
  assign fifo_pop   = fifo_valid && bus.trace_ready;

  tb_trace_fifo #(
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .tb_clk     (tb_clk),
    .reset      (reset),
    .push       (acc.wr8),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .valid      (fifo_valid),
    .full       (fifo_full)
  );

  assign bus.trace_valid = fifo_valid;
  assign bus.trace_addr  = fifo_head.addr;
  assign bus.trace_data  = fifo_head.data;

  // Sticky error flags; an entry is lost only when full with no pop.
  always_ff @(posedge tb_clk) begin
    if (reset) begin
      err_wr16       <= 1'b0;
      err_misalign   <= 1'b0;
      err_oob        <= 1'b0;
      trace_overflow <= 1'b0;
    end else begin
      if (acc.wr16)                             err_wr16       <= 1'b1;
      if (acc.misalign)                         err_misalign   <= 1'b1;
      if (acc.oob)                              err_oob        <= 1'b1;
      if (acc.wr8 && fifo_full && !fifo_pop)    trace_overflow <= 1'b1;
    end
  end

  // Saturating activity counters for reads and accepted byte writes.
  always_ff @(posedge tb_clk) begin
    if (reset) begin
      rd_count <= 16'h0000;
      wr_count <= 16'h0000;
    end else begin
      if (acc.rd)  rd_count <= sat_inc16(rd_count);
      if (acc.wr8) wr_count <= sat_inc16(wr_count);
    end
  end

endmodule : tb_mem_port

// File: tb/tb_tb_mem_port.sv
// Self-checking bench for tb_mem_port: directed steps from the test plan,
// then randomized traffic, all compared against a byte-array/queue model.
module tb_tb_mem_port;
  import pkg_cpu::*;
  import pkg_tb_mem::*;

  localparam int MB = 256;
  localparam int TD = 4;

  logic        tb_clk = 1'b0;
  logic        reset;
  logic        err_wr16;
  logic        err_misalign;
  logic        err_oob;
  logic        trace_overflow;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  tb_mem_port_if bus ();

  tb_mem_port #(
    .MEM_BYTES   (MB),
    .TRACE_DEPTH (TD)
  ) dut (
    .tb_clk         (tb_clk),
    .reset          (reset),
    .bus            (bus.slave),
    .err_wr16       (err_wr16),
    .err_misalign   (err_misalign),
    .err_oob        (err_oob),
    .trace_overflow (trace_overflow),
    .rd_count       (rd_count),
    .wr_count       (wr_count)
  );

  always #5 tb_clk = ~tb_clk;

  // Reference model state
  logic [7:0]    m_mem [MB];
  tb_trace_entry m_q [$];
  logic [15:0]   m_rdata;
  bit            m_wr16, m_mis, m_oob, m_ovf;
  int            m_rd, m_wr;

  int checks   = 0;
  int failures = 0;
  int step_no  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Apply the rules of one clock edge to the model, using the bench's own
  // stimulus as it stands at the edge.
  task automatic model_edge();
    int          idx;
    int          base;
    bit          wide;
    tb_trace_entry e;
    if (reset) begin
      if (bus.load_en) m_mem[int'(bus.load_addr) % MB] = bus.load_data;
      m_rdata = 16'h0000;
      m_q.delete();
      m_wr16 = 0; m_mis = 0; m_oob = 0; m_ovf = 0;
      m_rd = 0; m_wr = 0;
      return;
    end
    if (m_q.size() > 0 && bus.trace_ready) void'(m_q.pop_front());
    if (bus.load_en) begin
      m_mem[int'(bus.load_addr) % MB] = bus.load_data;
      return;
    end
    wide = (bus.cpu_acc_sz == cpu_data_acc_sz_16);
    if (int'(bus.cpu_addr) >= MB) m_oob = 1;
    idx = int'(bus.cpu_addr) % MB;
    if (!bus.cpu_we) begin
      if (m_rd < 65535) m_rd++;
      if (wide) begin
        base    = idx - (idx % 2);
        m_rdata = {m_mem[base], m_mem[base + 1]};
        if (int'(bus.cpu_addr) % 2 == 1) m_mis = 1;
      end else begin
        m_rdata = {8'h00, m_mem[idx]};
      end
    end else if (wide) begin
      m_wr16 = 1;
    end else begin
      m_mem[idx] = bus.cpu_wdata[7:0];
      if (m_wr < 65535) m_wr++;
      if (m_q.size() < TD) begin
        e.addr = 16'(idx);
        e.data = bus.cpu_wdata[7:0];
        m_q.push_back(e);
      end else begin
        m_ovf = 1;
      end
    end
  endtask

  task automatic compare_all();
    tb_trace_entry h;
    h = (m_q.size() > 0) ? m_q[0] : '0;
    chk($sformatf("s%0d_rdata", step_no),          bus.rdata,       m_rdata);
    chk($sformatf("s%0d_trace_valid", step_no),    bus.trace_valid, (m_q.size() > 0));
    chk($sformatf("s%0d_trace_addr", step_no),     bus.trace_addr,  h.addr);
    chk($sformatf("s%0d_trace_data", step_no),     bus.trace_data,  h.data);
    chk($sformatf("s%0d_err_wr16", step_no),       err_wr16,        m_wr16);
    chk($sformatf("s%0d_err_misalign", step_no),   err_misalign,    m_mis);
    chk($sformatf("s%0d_err_oob", step_no),        err_oob,         m_oob);
    chk($sformatf("s%0d_trace_overflow", step_no), trace_overflow,  m_ovf);
    chk($sformatf("s%0d_rd_count", step_no),       rd_count,        m_rd);
    chk($sformatf("s%0d_wr_count", step_no),       wr_count,        m_wr);
  endtask

  // One clock: model follows the edge, outputs are checked 1 time unit later.
  task automatic step();
    @(posedge tb_clk);
    model_edge();
    #1;
    compare_all();
    step_no++;
  endtask

  task automatic cpu_rd(input bit wide, input logic [15:0] addr);
    bus.load_en    = 1'b0;
    bus.cpu_we     = 1'b0;
    bus.cpu_acc_sz = wide ? cpu_data_acc_sz_16 : cpu_data_acc_sz_8;
    bus.cpu_addr   = addr;
    bus.cpu_wdata  = 16'(($urandom));
    step();
  endtask

  task automatic cpu_wr(input bit wide, input logic [15:0] addr, input logic [15:0] wdata);
    bus.load_en    = 1'b0;
    bus.cpu_we     = 1'b1;
    bus.cpu_acc_sz = wide ? cpu_data_acc_sz_16 : cpu_data_acc_sz_8;
    bus.cpu_addr   = addr;
    bus.cpu_wdata  = wdata;
    step();
  endtask

  initial begin
    logic [7:0] saved_10;
    logic [7:0] exp_order [4];
    saved_10 = 8'h00;

    reset           = 1'b1;
    bus.cpu_addr    = 16'h0000;
    bus.cpu_acc_sz  = cpu_data_acc_sz_8;
    bus.cpu_we      = 1'b0;
    bus.cpu_wdata   = 16'h0000;
    bus.load_en     = 1'b0;
    bus.load_addr   = 16'h0000;
    bus.load_data   = 8'h00;
    bus.trace_ready = 1'b0;

    // Preload the whole array while held in reset; CPU bus toggles randomly
    // and must be ignored.
    for (int i = 0; i < MB; i++) begin
      bus.load_en    = 1'b1;
      bus.load_addr  = 16'(i);
      case (i)
        0:       bus.load_data = 8'h12;
        1:       bus.load_data = 8'h34;
        2:       bus.load_data = 8'h56;
        3:       bus.load_data = 8'h78;
        default: bus.load_data = 8'($urandom);
      endcase
      if (i == 16) saved_10 = bus.load_data;
      bus.cpu_addr   = 16'($urandom);
      bus.cpu_we     = 1'($urandom);
      bus.cpu_acc_sz = 1'($urandom);
      bus.cpu_wdata  = 16'($urandom);
      step();
    end
    chk("reset_rdata", bus.rdata, 16'h0000);
    chk("reset_trace_valid", bus.trace_valid, 1'b0);
    chk("reset_counts", {rd_count, wr_count}, 32'h0);
    reset       = 1'b0;
    bus.load_en = 1'b0;

    // Big-endian 16-bit reads of the preloaded words.
    cpu_rd(1'b1, 16'h0000);
    chk("rd16_at_0", bus.rdata, 16'h1234);
    cpu_rd(1'b1, 16'h0002);
    chk("rd16_at_2", bus.rdata, 16'h5678);
    chk("rd_count_2", rd_count, 16'd2);

    // Byte write, then read-back next cycle; trace captures the store.
    cpu_wr(1'b0, 16'h0005, 16'h77AB);
    chk("trace_head_addr", bus.trace_addr, 16'h0005);
    chk("trace_head_data", bus.trace_data, 8'hAB);
    chk("wr_count_1", wr_count, 16'd1);
    cpu_rd(1'b0, 16'h0005);
    chk("rd8_after_wr", bus.rdata, 16'h00AB);

    // Drain that entry, then a rejected 16-bit write and a misaligned read.
    bus.trace_ready = 1'b1;
    cpu_rd(1'b0, 16'h0005);
    bus.trace_ready = 1'b0;
    chk("trace_drained", bus.trace_valid, 1'b0);
    cpu_wr(1'b1, 16'h0010, 16'hEEEE);
    chk("err_wr16_set", err_wr16, 1'b1);
    chk("wr16_not_traced", bus.trace_valid, 1'b0);
    chk("wr16_not_counted", wr_count, 16'd1);
    cpu_rd(1'b0, 16'h0010);
    chk("wr16_mem_unchanged", bus.rdata, {8'h00, saved_10});
    cpu_rd(1'b1, 16'h0003);
    chk("err_misalign_set", err_misalign, 1'b1);
    chk("rd16_misaligned", bus.rdata, 16'h5678);

    // Five writes into a four-deep trace with no consumer.
    for (int k = 0; k < 5; k++) cpu_wr(1'b0, 16'(32 + k), 16'(8'hC0 + k));
    chk("trace_overflow_set", trace_overflow, 1'b1);
    chk("full_head_oldest", bus.trace_data, 8'hC0);
    // Push and pop together while full: nothing further is lost.
    bus.trace_ready = 1'b1;
    cpu_wr(1'b0, 16'h0025, 16'h00C5);
    exp_order[0] = 8'hC1; exp_order[1] = 8'hC2;
    exp_order[2] = 8'hC3; exp_order[3] = 8'hC5;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain_order_%0d", k), bus.trace_data, exp_order[k]);
      cpu_rd(1'b0, 16'h0000);
    end
    chk("drain_empty", bus.trace_valid, 1'b0);
    bus.trace_ready = 1'b0;

    // Out-of-range address wraps and flags.
    cpu_rd(1'b0, 16'h0102);
    chk("oob_wrapped_rd", bus.rdata, 16'h0056);
    chk("err_oob_set", err_oob, 1'b1);

    // Mid-run reset clears state but keeps memory.
    cpu_wr(1'b0, 16'h0040, 16'h0011);
    reset = 1'b1;
    cpu_rd(1'b0, 16'h0000);
    reset = 1'b0;
    chk("rst_flags", {err_wr16, err_misalign, err_oob, trace_overflow}, 4'b0000);
    chk("rst_fifo", bus.trace_valid, 1'b0);
    chk("rst_rdata", bus.rdata, 16'h0000);
    cpu_rd(1'b0, 16'h0002);
    chk("mem_kept_after_rst", bus.rdata, 16'h0056);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      reset           = ($urandom_range(0, 63) == 0);
      bus.load_en     = ($urandom_range(0, 15) == 0);
      bus.load_addr   = 16'($urandom);
      bus.load_data   = 8'($urandom);
      bus.cpu_addr    = ($urandom_range(0, 7) == 0) ? 16'($urandom)
                                                    : 16'($urandom_range(0, 511));
      bus.cpu_we      = 1'($urandom);
      bus.cpu_acc_sz  = 1'($urandom);
      bus.cpu_wdata   = 16'($urandom);
      bus.trace_ready = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_tb_mem_port

// File: doc/tb_mem_port.md
# tb_mem_port

Test-bench memory port sitting directly downstream of the CPU data bus: it services every 8-bit and 16-bit access the CPU issues on `tb_clk`, returns registered read data for the CPU's instruction/data fetches, and performs byte writes. It also provides a preload path for programming memory while the CPU is held in reset, and a write-trace FIFO with valid/ready handshake so bench checkers can observe every store. Error and activity counters support regression checking.

## Interface
- `MEM_BYTES`, 256, byte capacity; power of two, ≥ 4
- `TRACE_DEPTH`, 4, write-trace FIFO entries; power of two, ≥ 2
- `tb_clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high; clock `tb_clk`
- `cpu_addr`  in  16  access byte address
- `cpu_acc_sz`  in  1  `pkg_cpu::cpu_data_acc_sz_8` / `cpu_data_acc_sz_16`
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_wdata`  in  16  write data; only [7:0] used
- `rdata`  out  16  registered read data
- `load_en`  in  1  preload byte write
- `load_addr`  in  16  preload address
- `load_data`  in  8  preload byte
- `trace_valid`  out  1  FIFO non-empty
- `trace_ready`  in  1  consumer pops head
- `trace_addr`  out  16  head entry address (masked)
- `trace_data`  out  8  head entry byte
- `err_wr16`  out  1  sticky: 16-bit write attempted
- `err_misalign`  out  1  sticky: 16-bit read at odd address
- `err_oob`  out  1  sticky: address ≥ `MEM_BYTES`
- `trace_overflow`  out  1  sticky: trace entry dropped
- `rd_count`  out  16  saturating count of CPU reads
- `wr_count`  out  16  saturating count of accepted CPU byte writes

## Operation
- Memory: byte array `MEM_BYTES` deep; indices are `addr & (MEM_BYTES-1)`, wrapping. Array is NOT cleared by reset.
- Big-endian: 16-bit read at A returns {mem[A&~1], mem[(A&~1)+1]}; A odd sets `err_misalign` and returns the aligned pair.
- 8-bit read: `rdata` = {8'h00, mem[A]}.
- 8-bit write: mem[A] ← `cpu_wdata[7:0]`; push {masked A, byte} to the trace FIFO; `wr_count`++.
- 16-bit write: memory unchanged, not traced, not counted; set `err_wr16`.
- Any CPU access with `cpu_addr` ≥ `MEM_BYTES` sets `err_oob`; access still proceeds on the wrapped address.
- Every cycle is a CPU access (the bus has no request strobe); each read cycle increments `rd_count`. Counters saturate at 16'hFFFF.
- `load_en` = 1: mem[`load_addr` masked] ← `load_data`; CPU access that cycle is ignored (no memory effect, no count, no trace, no flags); `rdata` holds its value.
- Trace FIFO: pop when `trace_valid && trace_ready`. Push when full and no pop → entry dropped, memory still written, `trace_overflow` set. Push and pop together while full → both performed, no overflow.

## Timing
- Read latency 1: address sampled at edge N, `rdata` valid after edge N, held until the next read edge; write cycles do not change `rdata`.
- Write at edge N is visible to a read sampled at edge N+1.
- Trace entry pushed at edge N drives `trace_valid` = 1 after edge N; head outputs are stable while `trace_valid && !trace_ready`.
- Reset (edge with `reset` = 1): `rdata` = 0, FIFO empty (`trace_valid` = 0, `trace_addr`/`trace_data` = 0), all sticky flags 0, counters 0. CPU accesses are ignored during reset; `load_en` preload IS performed during reset, so programs load while the CPU is held.
- Reset mid-operation: FIFO contents discarded; memory contents retained.

## Structure
- `pkg_tb_mem`: `tb_trace_entry` struct {addr[15:0], data[7:0]}, default `MEM_BYTES`/`TRACE_DEPTH` constants; access-size encodings reused from `pkg_cpu`.
- Sub-module `tb_trace_fifo`: synchronous FIFO of `tb_trace_entry`, pointers one bit wider than log2(depth), full/empty from pointer compare, simultaneous push/pop support.

## Test plan
- Preload 0x00..0x03 = 12 34 56 78 during reset; 16-bit reads at 0 then 2 → `rdata` 16'h1234 then 16'h5678, `rd_count` = 2.
- 8-bit write 0xAB to 0x05, 8-bit read 0x05 next cycle → `rdata` 16'h00AB; trace head {0x0005, 0xAB}, `wr_count` = 1.
- 16-bit write to 0x10 → mem[0x10] unchanged, `err_wr16` = 1, `trace_valid` stays 0; 16-bit read at 0x03 → `err_misalign` = 1, `rdata` = 16'h5678.
- `trace_ready` = 0, five 8-bit writes (DEPTH 4) → 4 entries kept in order, `trace_overflow` = 1; then push+pop while full → no further loss, order preserved.
- 8-bit read at 0x0102 (MEM_BYTES 256) → returns mem[0x02], `err_oob` = 1; assert reset → flags, counters, FIFO cleared, mem[0x02] still 0x56.
